// File: rtl/vram_arbiter.sv
// VRAM bus arbiter/sequencer: fixed-priority grant (PPU > DMA > CPU) followed by a
// setup/strobe/finish access cycle, with CPU lockout while the PPU is rendering.
module vram_arbiter #(
    parameter int ACC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ppu_req,
    input  logic [12:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_lock,
    output logic [12:0] vram_a,
    output logic [7:0]  vram_d_out,
    input  logic [7:0]  vram_d_in,
    output logic        vram_d_oe,
    output logic        vram_cs,
    output logic        vram_oe,
    output logic        vram_we,
    output logic [2:0]  grant,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_FINISH, S_LOCKACK} state_t;

    localparam logic [1:0] CNT_LAST = 2'(ACC_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_grant;
    logic [1:0]  r_cnt;
    logic [12:0] r_addr;
    logic        r_we;
    logic [7:0]  r_wdata;
    logic [7:0]  r_ppu_rdata;
    logic [7:0]  r_dma_rdata;
    logic [7:0]  r_cpu_rdata;

    logic [2:0]  w_req;
    logic [2:0]  w_win;
    logic        w_arb;
    logic        w_last;
    logic [12:0] w_sel_addr;
    logic        w_sel_we;
    logic [7:0]  w_sel_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = {ppu_req, dma_req, cpu_req};
        w_win       = 3'b000;
        w_arb       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_FINISH, S_LOCKACK: begin
                w_arb = 1'b1;
                // The requester being acked this cycle may not win again immediately.
                if (r_state != S_IDLE) w_req = w_req & ~r_grant;
                if (w_req[2])      w_win = 3'b100;
                else if (w_req[1]) w_win = 3'b010;
                else if (w_req[0]) w_win = 3'b001;
                if (w_win == 3'b000)           w_state_nxt = S_IDLE;
                else if (w_win[0] && ppu_lock) w_state_nxt = S_LOCKACK;
                else                           w_state_nxt = S_SETUP;
            end
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_FINISH;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_addr  = cpu_addr;
        w_sel_we    = cpu_we;
        w_sel_wdata = cpu_wdata;
        if (w_win[2]) begin
            w_sel_addr  = ppu_addr;
            w_sel_we    = 1'b0;
            w_sel_wdata = r_wdata;
        end else if (w_win[1]) begin
            w_sel_addr  = dma_addr;
            w_sel_we    = 1'b0;
            w_sel_wdata = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'b000;
            r_cnt       <= 2'd0;
            r_addr      <= 13'd0;
            r_we        <= 1'b0;
            r_wdata     <= 8'd0;
            r_ppu_rdata <= 8'hFF;
            r_dma_rdata <= 8'hFF;
            r_cpu_rdata <= 8'hFF;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) begin
                r_grant <= w_win;
                // Locked CPU accesses never reach the bus, so nothing is latched for them.
                if (w_state_nxt == S_SETUP) begin
                    r_addr  <= w_sel_addr;
                    r_we    <= w_sel_we;
                    r_wdata <= w_sel_wdata;
                end
                if (w_state_nxt == S_LOCKACK) r_cpu_rdata <= 8'hFF;
            end
            if (r_state == S_SETUP)       r_cnt <= 2'd0;
            else if (r_state == S_STROBE) r_cnt <= r_cnt + 2'd1;
            if (w_last && !r_we) begin
                if (r_grant[2]) r_ppu_rdata <= vram_d_in;
                if (r_grant[1]) r_dma_rdata <= vram_d_in;
                if (r_grant[0]) r_cpu_rdata <= vram_d_in;
            end
        end
    end

    assign vram_a     = r_addr;
    assign vram_d_out = r_wdata;
    assign vram_cs    = (r_state == S_SETUP) || (r_state == S_STROBE);
    assign vram_oe    = (r_state == S_STROBE) && !r_we;
    assign vram_we    = (r_state == S_STROBE) && r_we;
    // Data stays driven through FINISH to give the RAM write hold time.
    assign vram_d_oe  = r_we && ((r_state == S_SETUP) || (r_state == S_STROBE) ||
                                 (r_state == S_FINISH));
    assign ppu_ack    = (r_state == S_FINISH) && r_grant[2];
    assign dma_ack    = (r_state == S_FINISH) && r_grant[1];
    assign cpu_ack    = ((r_state == S_FINISH) && r_grant[0]) || (r_state == S_LOCKACK);
    assign ppu_rdata  = r_ppu_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a simple VRAM model whose contents start as addr[7:0]^0xA5.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ppu_req, dma_req, cpu_req, cpu_we, ppu_lock;
    logic [12:0] ppu_addr, dma_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ppu_ack, dma_ack, cpu_ack;
    logic [7:0]  ppu_rdata, dma_rdata, cpu_rdata;
    logic [12:0] vram_a;
    logic [7:0]  vram_d_out, vram_d_in;
    logic        vram_d_oe, vram_cs, vram_oe, vram_we, busy;
    logic [2:0]  grant;

    logic [7:0]  mem [0:8191];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.ACC_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ppu_lock(ppu_lock),
        .vram_a(vram_a), .vram_d_out(vram_d_out), .vram_d_in(vram_d_in),
        .vram_d_oe(vram_d_oe), .vram_cs(vram_cs), .vram_oe(vram_oe), .vram_we(vram_we),
        .grant(grant), .busy(busy)
    );

    assign vram_d_in = mem[vram_a];
    always @(posedge clk) if (vram_we) mem[vram_a] <= vram_d_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ack(input int sel, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((sel == 0 && cpu_ack) || (sel == 1 && dma_ack) || (sel == 2 && ppu_ack)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int we_n, doe_n, ack_at, n;
        int ppu_at, dma_at, cpu_at, ppu_cnt, cpu_cnt;
        logic a_ok, d_ok, strobe_seen;
        logic [2:0] g1, g5, g9;

        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'hA5;
        reset = 1'b1; ppu_req = 0; dma_req = 0; cpu_req = 0; cpu_we = 0; ppu_lock = 0;
        ppu_addr = '0; dma_addr = '0; cpu_addr = '0; cpu_wdata = '0;

        // Reset
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_strobes", {vram_cs, vram_oe, vram_we, vram_d_oe}, 0);
        chk("rst_acks", {ppu_ack, dma_ack, cpu_ack}, 0);
        chk("rst_vram_a", vram_a, 0);
        chk("rst_rdata", {ppu_rdata, dma_rdata, cpu_rdata}, 24'hFFFFFF);

        // CPU write 0x5A -> 0x1ABC
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1ABC; cpu_wdata = 8'h5A;
        we_n = 0; doe_n = 0; ack_at = -1; a_ok = 1; d_ok = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (vram_we) begin
                we_n++;
                if (vram_a != 13'h1ABC) a_ok = 0;
                if (vram_d_out != 8'h5A) d_ok = 0;
            end
            if (vram_d_oe) doe_n++;
            if (cpu_ack) begin
                ack_at = c;
                cpu_req = 0; cpu_we = 0;
            end
        end
        chk("wr_we_cycles", we_n, 2);
        chk("wr_doe_cycles", doe_n, 4);
        chk("wr_ack_cycle", ack_at, 4);
        chk("wr_addr", a_ok, 1);
        chk("wr_data", d_ok, 1);
        chk("wr_mem", mem[13'h1ABC], 8'h5A);
        chk("wr_idle", busy, 0);

        // Simultaneous PPU/DMA/CPU reads
        ppu_req = 1; ppu_addr = 13'h0800;
        dma_req = 1; dma_addr = 13'h0101;
        cpu_req = 1; cpu_addr = 13'h0000; cpu_we = 0;
        ppu_at = 100; dma_at = 100; cpu_at = 100; ppu_cnt = 0; cpu_cnt = 0;
        g1 = 0; g5 = 0; g9 = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            // Each requester keeps its request up through its own ack cycle.
            if (c == ppu_at + 1) ppu_req = 0;
            if (c == dma_at + 1) dma_req = 0;
            if (c == cpu_at + 1) cpu_req = 0;
            if (ppu_ack) begin ppu_at = c; ppu_cnt++; end
            if (dma_ack) dma_at = c;
            if (cpu_ack) begin cpu_at = c; cpu_cnt++; end
            if (c == 1) g1 = grant;
            if (c == 5) g5 = grant;
            if (c == 9) g9 = grant;
        end
        chk("pri_grant1", g1, 3'b100);
        chk("pri_grant2", g5, 3'b010);
        chk("pri_grant3", g9, 3'b001);
        chk("pri_ppu_ack", ppu_at, 4);
        chk("pri_dma_ack", dma_at, 8);
        chk("pri_cpu_ack", cpu_at, 12);
        chk("pri_ppu_once", ppu_cnt, 1);
        chk("pri_cpu_once", cpu_cnt, 1);
        chk("pri_ppu_rdata", ppu_rdata, 8'hA5);
        chk("pri_dma_rdata", dma_rdata, 8'hA4);
        chk("pri_cpu_rdata", cpu_rdata, 8'hA5);

        // Locked CPU read
        ppu_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0000;
        tick();
        chk("lk_rd_ack", cpu_ack, 1);
        chk("lk_rd_rdata", cpu_rdata, 8'hFF);
        chk("lk_rd_strobes", {vram_cs, vram_oe, vram_we, vram_d_oe}, 0);
        cpu_req = 0;
        tick();
        chk("lk_rd_idle", {busy, cpu_ack}, 0);

        // Locked CPU write is dropped
        cpu_req = 1; cpu_we = 1; cpu_wdata = 8'h77;
        strobe_seen = 0;
        wait_ack(0, 8, n);
        if (vram_cs || vram_we || vram_d_oe) strobe_seen = 1;
        cpu_req = 0; cpu_we = 0;
        tick();
        if (vram_cs || vram_we || vram_d_oe) strobe_seen = 1;
        chk("lk_wr_ack", n, 1);
        chk("lk_wr_nostrobe", strobe_seen, 0);

        ppu_lock = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0000;
        wait_ack(0, 10, n);
        cpu_req = 0;
        chk("unlk_rd_lat", n, 4);
        chk("unlk_rd_data", cpu_rdata, 8'hA5);
        tick();

        // Lock rising during a CPU read does not abort it
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0042;
        tick(); tick();
        ppu_lock = 1;
        wait_ack(0, 10, n);
        cpu_req = 0;
        chk("midlk_lat", n, 2);
        chk("midlk_data", cpu_rdata, 8'hE7);
        ppu_lock = 0;
        tick();

        // DMA request dropped after SETUP still completes
        dma_req = 1; dma_addr = 13'h0033;
        tick();
        chk("drop_setup_cs", vram_cs, 1);
        dma_req = 0;
        wait_ack(1, 10, n);
        chk("drop_ack_lat", n, 3);
        chk("drop_rdata", dma_rdata, 8'h96);
        tick();
        chk("drop_idle", busy, 0);

        // Reset during DMA STROBE
        dma_req = 1; dma_addr = 13'h0010;
        tick(); tick();
        chk("rmid_in_strobe", vram_oe, 1);
        reset = 1;
        tick();
        chk("rmid_idle", {busy, grant}, 0);
        chk("rmid_oe", vram_oe, 0);
        chk("rmid_noack", dma_ack, 0);
        chk("rmid_rdata", dma_rdata, 8'hFF);
        reset = 0;
        wait_ack(1, 10, n);
        dma_req = 0;
        chk("rmid_fresh_lat", n, 4);
        chk("rmid_fresh_data", dma_rdata, 8'hB5);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
